maxpool2x2_stream: RTL and testbench

//  Streaming 2x2/stride-2 signed max-pool for the UNet encoder (downsampling path), the counterpart of transconv's 2x upsampling.

---
 rtl/unet_pkg.sv | 30 +++
 rtl/pool_line_buf.sv | 45 ++++
 rtl/maxpool2x2_stream.sv | 210 +++++++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unet_pkg.sv
// -----------------------------------------------------------------------------
// unet_pkg
// Shared definitions for the UNet encoder/decoder streaming blocks.
//   POOL_DATA_W    default signed pixel width
//   POOL_MAX_WIDTH default largest input image width for the pooling stage
//   POOL_DIM_W     default width of image dimension ports
//   SMAX_W         working width of smax(); callers sign-extend into it so
//                  one function serves any pixel width up to 32 bits
//   dim_t          image dimension type at the default dimension width
//   smax()         signed maximum of two values
// -----------------------------------------------------------------------------
package unet_pkg;

  localparam int POOL_DATA_W    = 8;
  localparam int POOL_MAX_WIDTH = 128;
  localparam int POOL_DIM_W     = 8;
  localparam int SMAX_W         = 32;

  typedef logic [POOL_DIM_W-1:0] dim_t;

  // Signed max. Operands are sign-extended by the caller, so the result
  // always fits back into the caller's original width.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Single-write / single-read synchronous RAM holding the horizontal pair maxima
// of the previous (even) image row. Contents are not reset; every entry is
// rewritten by an even row before the following odd row reads it.
// Ports:
//   clk        clock, rising edge
//   wr_en_i    write strobe
//   wr_addr_i  write address (pair index = column >> 1)
//   wr_data_i  pair maximum to store
//   rd_en_i    read strobe; rd_data_o updates only when it is high
//   rd_addr_i  read address
//   rd_data_o  registered read data, held between reads
// -----------------------------------------------------------------------------
module pool_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read and write never target the same row pair in the same cycle (writes
  // happen on even rows, reads on odd rows), so no bypass is needed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
// Streaming 2x2 / stride-2 signed max-pool. Takes a raster-order pixel stream
// of a width x height map and emits the floor(W/2) x floor(H/2) pooled map in
// raster order, one pooled pixel per complete 2x2 window.
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous soft clear: abort frame, counters to 0 (wins over
//               in_valid)
//   width       input image width, 2..MAX_WIDTH, latched on first pixel
//   height      input image height, >= 2, latched on first pixel
//   in_valid    a pixel is present on in this cycle
//   in          signed input pixel
//   out_valid   one-cycle pulse, out holds a pooled pixel
//   out         signed pooled pixel (max of a 2x2 window), held between pulses
//   out_last    with out_valid: last pooled pixel of the frame
//   frame_done  one-cycle pulse after the final input pixel is accepted
// Dataflow:
//   even column  -> hmax_q holds the left pixel; odd rows also launch the
//                   line-buffer read for this column pair
//   odd column   -> even row: store max(left,right) in the line buffer
//                   odd row : out = max(max(left,right), line-buffer data)
// -----------------------------------------------------------------------------
module maxpool2x2_stream
  import unet_pkg::*;
#(
  parameter int DATA_W    = POOL_DATA_W,
  parameter int MAX_WIDTH = POOL_MAX_WIDTH,
  parameter int DIM_W     = POOL_DIM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_last,
  output logic              frame_done
);

  localparam int DEPTH = MAX_WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [DATA_W-1:0] hmax_q, hmax_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------
  // Frame geometry
  // ---------------------------------------------------------------------------
  logic             first_px;
  logic [DIM_W-1:0] eff_w;
  logic [DIM_W-1:0] eff_h;
  logic [DIM_W-1:0] last_win_col;
  logic [DIM_W-1:0] last_win_row;
  logic             last_col;
  logic             last_row;
  logic             is_last_win;

  // On the first pixel of a frame the latched dims are stale, so decisions
  // for that pixel use the live ports (same values that get latched).
  assign first_px = (col_q == '0) && (row_q == '0);
  assign eff_w    = first_px ? width  : w_q;
  assign eff_h    = first_px ? height : h_q;

  assign last_col = (col_q == eff_w - DIM_W'(1));
  assign last_row = (row_q == eff_h - DIM_W'(1));

  // Bottom-right pixel of the final complete window: an odd trailing
  // column/row is discarded, so round the dimension down to even first.
  assign last_win_col = {eff_w[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign last_win_row = {eff_h[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign is_last_win  = (col_q == last_win_col) && (row_q == last_win_row);

  // ---------------------------------------------------------------------------
  // Line buffer control
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              buf_wr_en;
  logic              buf_rd_en;
  logic [AW-1:0]     buf_addr;
  logic [DATA_W-1:0] buf_rdata;

  assign accept    = in_valid && !clr;
  // Reads are launched on the even column so data is ready for the odd one.
  assign buf_rd_en = accept && !col_q[0] &&  row_q[0];
  assign buf_wr_en = accept &&  col_q[0] && !row_q[0];
  assign buf_addr  = col_q[AW:1];

  // ---------------------------------------------------------------------------
  // Compare tree
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;

  // Operands are sign-extended into smax()'s working width; the result is
  // always one of the operands, so truncating back is lossless.
  assign pair_max = DATA_W'(smax(SMAX_W'($signed(hmax_q)),
                                 SMAX_W'($signed(in))));
  assign win_max  = DATA_W'(smax(SMAX_W'($signed(pair_max)),
                                 SMAX_W'($signed(buf_rdata))));

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr_en),
    .wr_addr_i (buf_addr),
    .wr_data_i (pair_max),
    .rd_en_i   (buf_rd_en),
    .rd_addr_i (buf_addr),
    .rd_data_o (buf_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    h_d          = h_q;
    hmax_d       = hmax_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    frame_done_d = 1'b0;

    if (clr) begin
      // Abort: any pixel presented this cycle is dropped; out keeps its value.
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (first_px) begin
        w_d = width;
        h_d = height;
      end

      if (!col_q[0]) begin
        hmax_d = in;
      end

      if (col_q[0] && row_q[0]) begin
        out_d       = win_max;
        out_valid_d = 1'b1;
        out_last_d  = is_last_win;
      end

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + DIM_W'(1);
        end
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      hmax_q       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      h_q          <= h_d;
      hmax_q       <= hmax_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
// Scoreboard bench: when the bottom-right pixel of a window is driven, the
// window max (computed from the whole frame image held in pix[]) is queued
// with the cycle it must appear on. A negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] width;
  logic [7:0] height;
  logic       in_valid;
  logic [7:0] in;
  logic       out_valid;
  logic [7:0] out;
  logic       out_last;
  logic       frame_done;

  always #5 clk = ~clk;

  maxpool2x2_stream #(
    .DATA_W    (8),
    .MAX_WIDTH (128),
    .DIM_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .width      (width),
    .height     (height),
    .in_valid   (in_valid),
    .in         (in),
    .out_valid  (out_valid),
    .out        (out),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] val;
    logic       last;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   pix[256];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t mon_e;
  int   mon_fd;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stray_out: got out=%0d at cyc %0d, required no output",
                 $signed(out), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out !== mon_e.val || out_last !== mon_e.last || cyc !== mon_e.due) begin
          failures++;
          $display("FAIL pooled_out: got out=%0d last=%0b cyc=%0d, required out=%0d last=%0b cyc=%0d",
                   $signed(out), out_last, cyc, $signed(mon_e.val), mon_e.last, mon_e.due);
        end else begin
          $display("out %0d last=%0b cyc=%0d ok", $signed(out), out_last, cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      checks++;
      failures++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_out: got no out_valid at cyc %0d, required out=%0d",
               cyc, $signed(mon_e.val));
    end

    if (frame_done === 1'b1) begin
      checks++;
      if (fd_q.size() == 0) begin
        failures++;
        $display("FAIL stray_frame_done: got pulse at cyc %0d, required none", cyc);
      end else begin
        mon_fd = fd_q.pop_front();
        if (cyc !== mon_fd) begin
          failures++;
          $display("FAIL frame_done_time: got cyc %0d, required cyc %0d", cyc, mon_fd);
        end else begin
          $display("frame_done cyc=%0d ok", cyc);
        end
      end
    end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
      checks++;
      failures++;
      mon_fd = fd_q.pop_front();
      $display("FAIL missing_frame_done: got none by cyc %0d, required cyc %0d", cyc, mon_fd);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in       = d;
  endtask

  task automatic load_basic();
    int vals[16] = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
    for (int k = 0; k < 16; k++) pix[k] = vals[k];
  endtask

  task automatic load_random(input int n);
    for (int k = 0; k < n; k++) pix[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Drive the first npix pixels of a w x h frame from pix[]; queue expected
  // results as each window completes. width/height are scrambled after the
  // first pixel to show they are only sampled once per frame.
  task automatic run_frame(input int w, input int h, input int npix,
                           input bit gaps, input int tail);
    int   c, r, m;
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      c = k % w;
      r = k / w;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) tick(1'b0, 8'($urandom));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in       = 8'(pix[k]);
      if (k == 0) begin
        width  = 8'(w);
        height = 8'(h);
      end else if (k == 1) begin
        width  = 8'd2;
        height = 8'd2;
      end
      if ((c % 2) == 1 && (r % 2) == 1) begin
        m = pix[(r - 1) * w + c - 1];
        if (pix[(r - 1) * w + c] > m) m = pix[(r - 1) * w + c];
        if (pix[r * w + c - 1] > m)   m = pix[r * w + c - 1];
        if (pix[r * w + c] > m)       m = pix[r * w + c];
        e.val  = 8'(m);
        e.last = (c == (w / 2) * 2 - 1) && (r == (h / 2) * 2 - 1);
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
      if (k == w * h - 1) fd_q.push_back(cyc + 1);
    end
    repeat (tail) tick(1'b0, 8'($urandom));
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out !== 8'd0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got valid=%0b out=%0d last=%0b done=%0b, required all 0",
               out_valid, out, out_last, frame_done);
    end else begin
      $display("reset state ok");
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 8'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%0b out=%0d done=%0b, required 0",
               out_valid, out, frame_done);
    end
  endtask

  task automatic test_basic();
    load_basic();
    run_frame(4, 4, 16, 1'b0, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: got %0d/%0d pending, required 0/0", exp_q.size(), fd_q.size());
    end
  endtask

  task automatic test_signed();
    for (int k = 0; k < 16; k++) pix[k] = -128;
    run_frame(4, 4, 16, 1'b0, 4);
    pix[15] = 127;
    run_frame(4, 4, 16, 1'b0, 4);
    checks++;
    if (out !== 8'd127) begin
      failures++;
      $display("FAIL signed_last: got %0d, required 127", $signed(out));
    end
  endtask

  task automatic test_odd_dims();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) pix[r * 5 + c] = r * 5 + c;
    run_frame(5, 3, 15, 1'b0, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0 || out !== 8'd8) begin
      failures++;
      $display("FAIL odd_dims: got pending %0d/%0d out=%0d, required 0/0 out=8",
               exp_q.size(), fd_q.size(), $signed(out));
    end
  endtask

  task automatic test_gaps();
    load_basic();
    run_frame(4, 4, 16, 1'b1, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL gaps_drain: got %0d/%0d pending, required 0/0", exp_q.size(), fd_q.size());
    end
  endtask

  task automatic test_clr();
    load_basic();
    run_frame(4, 4, 6, 1'b0, 0);
    @(posedge clk);
    #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    in       = 8'd127;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    load_random(16);
    run_frame(4, 4, 16, 1'b0, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL clr_drain: got %0d/%0d pending, required 0/0", exp_q.size(), fd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    load_basic();
    run_frame(4, 4, 16, 1'b0, 0);
    load_random(16);
    run_frame(8, 2, 16, 1'b0, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", exp_q.size(), fd_q.size());
    end
  endtask

  task automatic test_rst_mid_frame();
    load_basic();
    run_frame(4, 4, 6, 1'b0, 0);
    // The accepting edge of pixel (1,1) raises out_valid with out=14;
    // reset arrives while that pulse is still high.
    @(posedge clk);
    #7;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 8'd0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got valid=%0b out=%0d last=%0b done=%0b, required all 0",
               out_valid, $signed(out), out_last, frame_done);
    end
    exp_q.delete();
    fd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_random(16);
    run_frame(4, 4, 16, 1'b0, 4);
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_drain: got %0d/%0d pending, required 0/0", exp_q.size(), fd_q.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 8'd0;
    width    = 8'd4;
    height   = 8'd4;
    test_reset();
    test_basic();
    test_signed();
    test_odd_dims();
    test_gaps();
    test_clr();
    test_back_to_back();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
